// File: rtl/fluid_pio_pkg.sv
// rtl/fluid_pio_pkg.sv - shared constants and types for the fluid board PIO input block
//
// Purpose: register map addresses, maximum channel count and the register
//          address type used by fluid_pio_edge_capture.
// Ports:   none (package).

package fluid_pio_pkg;

    typedef logic [2:0] pio_addr_t;

    // Bus data width; also the maximum number of input channels.
    localparam int WIDTH_MAX = 32;

    localparam pio_addr_t ADDR_DATA      = 3'd0;
    localparam pio_addr_t ADDR_RAW       = 3'd1;
    localparam pio_addr_t ADDR_IRQ_MASK  = 3'd2;
    localparam pio_addr_t ADDR_EDGE_CAP  = 3'd3;
    localparam pio_addr_t ADDR_RISE_EN   = 3'd4;
    localparam pio_addr_t ADDR_FALL_EN   = 3'd5;
    localparam pio_addr_t ADDR_DB_PERIOD = 3'd6;

endpackage

// File: rtl/fluid_pio_debounce.sv
// rtl/fluid_pio_debounce.sv - one input channel: synchroniser, debounce filter, edge detect
//
// Purpose: synchronises one asynchronous input and accepts a change only after
//          it has persisted for db_period+1 consecutive cycles.
// Ports:
//   clk        system clock
//   reset_n    asynchronous active-low reset
//   in         asynchronous external input
//   db_period  debounce period in clk cycles
//   db_clr     clears the debounce counter (period register written)
//   sync       synchroniser output
//   stable     debounced value
//   rise/fall  single-cycle pulses on debounced 0->1 / 1->0

module fluid_pio_debounce #(
    parameter int SYNC_STAGES = 2,
    parameter int DB_BITS     = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               in,
    input  logic [DB_BITS-1:0] db_period,
    input  logic               db_clr,
    output logic               sync,
    output logic               stable,
    output logic               rise,
    output logic               fall
);

    logic [SYNC_STAGES-1:0] sync_ff;
    logic [DB_BITS-1:0]     cnt;
    logic                   stable_d;

    assign sync = sync_ff[SYNC_STAGES-1];
    assign rise = stable & ~stable_d;
    assign fall = ~stable & stable_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_ff  <= '0;
            cnt      <= '0;
            stable   <= 1'b0;
            stable_d <= 1'b0;
        end else begin
            sync_ff  <= {sync_ff[SYNC_STAGES-2:0], in};
            stable_d <= stable;
            // A period change restarts any pending qualification from scratch.
            if (db_clr) begin
                cnt <= '0;
            end else if (sync == stable) begin
                cnt <= '0;
            end else if (cnt >= db_period) begin
                stable <= sync;
                cnt    <= '0;
            end else if (cnt != '1) begin
                cnt <= cnt + DB_BITS'(1);
            end
        end
    end

endmodule

// File: rtl/fluid_pio_edge_capture.sv
// rtl/fluid_pio_edge_capture.sv - debounced PIO input block with edge capture and irq
//
// Purpose: WIDTH debounced inputs, rise/fall edge capture, per-bit level or
//          edge interrupt, Avalon-MM register slave with registered read data.
// Ports:
//   clk         system clock
//   reset_n     asynchronous active-low reset
//   address     register word address
//   chipselect  slave select
//   write_n     active-low write strobe
//   writedata   write data
//   readdata    registered read data, zero-extended
//   in_port     asynchronous external inputs
//   irq         interrupt request, active high

module fluid_pio_edge_capture
    import fluid_pio_pkg::*;
#(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int DB_BITS     = 16,
    parameter int DB_RESET    = 1000
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [2:0]           address,
    input  logic                 chipselect,
    input  logic                 write_n,
    input  logic [31:0]          writedata,
    output logic [31:0]          readdata,
    input  logic [WIDTH-1:0]     in_port,
    output logic                 irq
);

    pio_addr_t            reg_addr;
    logic                 wr_en;
    logic                 db_clr;
    logic [WIDTH-1:0]     wdata;
    logic                 unused_wdata;

    logic [WIDTH-1:0]     sync;
    logic [WIDTH-1:0]     stable;
    logic [WIDTH-1:0]     rise;
    logic [WIDTH-1:0]     fall;

    logic [WIDTH-1:0]     irq_mask;
    logic [WIDTH-1:0]     edge_cap;
    logic [WIDTH-1:0]     rise_en;
    logic [WIDTH-1:0]     fall_en;
    logic [DB_BITS-1:0]   db_period;

    logic [WIDTH-1:0]     ec_clr;
    logic [WIDTH-1:0]     edge_mode;
    logic [WIDTH-1:0]     irq_src;
    logic [WIDTH_MAX-1:0] rd_next;

    assign reg_addr     = address;
    assign wr_en        = chipselect & ~write_n;
    assign db_clr       = wr_en && (reg_addr == ADDR_DB_PERIOD);
    assign wdata        = writedata[WIDTH-1:0];
    assign unused_wdata = ^writedata;

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        fluid_pio_debounce #(
            .SYNC_STAGES (SYNC_STAGES),
            .DB_BITS     (DB_BITS)
        ) u_db (
            .clk       (clk),
            .reset_n   (reset_n),
            .in        (in_port[i]),
            .db_period (db_period),
            .db_clr    (db_clr),
            .sync      (sync[i]),
            .stable    (stable[i]),
            .rise      (rise[i]),
            .fall      (fall[i])
        );
    end

    assign ec_clr    = (wr_en && (reg_addr == ADDR_EDGE_CAP)) ? wdata : '0;
    // A bit with either edge enable set reports its capture flag; otherwise
    // it reports the debounced level.
    assign edge_mode = rise_en | fall_en;
    assign irq_src   = (edge_mode & edge_cap) | (~edge_mode & stable);

    always_comb begin
        rd_next = '0;
        case (reg_addr)
            ADDR_DATA:      rd_next[WIDTH-1:0]   = stable;
            ADDR_RAW:       rd_next[WIDTH-1:0]   = sync;
            ADDR_IRQ_MASK:  rd_next[WIDTH-1:0]   = irq_mask;
            ADDR_EDGE_CAP:  rd_next[WIDTH-1:0]   = edge_cap;
            ADDR_RISE_EN:   rd_next[WIDTH-1:0]   = rise_en;
            ADDR_FALL_EN:   rd_next[WIDTH-1:0]   = fall_en;
            ADDR_DB_PERIOD: rd_next[DB_BITS-1:0] = db_period;
            default:        rd_next              = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata  <= '0;
            irq       <= 1'b0;
            irq_mask  <= '0;
            edge_cap  <= '0;
            rise_en   <= '0;
            fall_en   <= '0;
            db_period <= DB_BITS'(DB_RESET);
        end else begin
            readdata <= rd_next;
            irq      <= |(irq_mask & irq_src);
            // Set terms are OR-ed after the clear so a new edge is never lost.
            edge_cap <= (edge_cap & ~ec_clr) | (rise & rise_en) | (fall & fall_en);
            if (wr_en) begin
                case (reg_addr)
                    ADDR_IRQ_MASK:  irq_mask  <= wdata;
                    ADDR_RISE_EN:   rise_en   <= wdata;
                    ADDR_FALL_EN:   fall_en   <= wdata;
                    ADDR_DB_PERIOD: db_period <= writedata[DB_BITS-1:0];
                    default:        ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fluid_pio_edge_capture.sv
// tb/tb_fluid_pio_edge_capture.sv - self-checking bench for fluid_pio_edge_capture

module tb_fluid_pio_edge_capture;

    localparam int W = 4;
    localparam int S = 2;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [W-1:0] in_port;
    logic        irq;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fluid_pio_edge_capture #(
        .WIDTH       (W),
        .SYNC_STAGES (S),
        .DB_BITS     (16),
        .DB_RESET    (1000)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .in_port    (in_port),
        .irq        (irq)
    );

    // Reference model: inputs seen S edges ago form the synchronised value;
    // a level is accepted after db_period+1 consecutive disagreeing samples.
    logic [W-1:0] hist[$];
    logic [W-1:0] m_stable, m_prev_stable;
    logic [W-1:0] m_mask, m_ec, m_ren, m_fen;
    logic [15:0]  m_period;
    int           m_age[W];
    logic [31:0]  m_rd;
    logic         m_irq;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        for (int k = 0; k < S; k++) hist.push_back('0);
        m_stable = '0; m_prev_stable = '0;
        m_mask = '0; m_ec = '0; m_ren = '0; m_fen = '0;
        m_period = 16'd1000;
        for (int i = 0; i < W; i++) m_age[i] = 0;
        m_rd = '0; m_irq = 1'b0;
    endtask

    function automatic logic [31:0] model_read(input logic [2:0] a);
        case (a)
            3'd0: return 32'(m_stable);
            3'd1: return 32'(hist[0]);
            3'd2: return 32'(m_mask);
            3'd3: return 32'(m_ec);
            3'd4: return 32'(m_ren);
            3'd5: return 32'(m_fen);
            3'd6: return 32'(m_period);
            default: return 32'd0;
        endcase
    endfunction

    // Advance the model across one rising edge using the inputs present at it.
    task automatic model_edge();
        logic         wr;
        logic [W-1:0] rises, falls, src, clr, sync_now, new_stable;
        wr       = chipselect && !write_n;
        sync_now = hist[0];
        rises    = m_stable & ~m_prev_stable;
        falls    = ~m_stable & m_prev_stable;
        for (int i = 0; i < W; i++)
            src[i] = (m_ren[i] || m_fen[i]) ? m_ec[i] : m_stable[i];
        m_irq = |(m_mask & src);
        m_rd  = model_read(address);
        clr   = (wr && address == 3'd3) ? writedata[W-1:0] : '0;
        m_ec  = (m_ec & ~clr) | (rises & m_ren) | (falls & m_fen);
        new_stable = m_stable;
        for (int i = 0; i < W; i++) begin
            if (wr && address == 3'd6) begin
                m_age[i] = 0;
            end else if (sync_now[i] != m_stable[i]) begin
                m_age[i]++;
                if (m_age[i] == int'(m_period) + 1) begin
                    new_stable[i] = sync_now[i];
                    m_age[i] = 0;
                end
            end else begin
                m_age[i] = 0;
            end
        end
        m_prev_stable = m_stable;
        m_stable = new_stable;
        if (wr) begin
            case (address)
                3'd2: m_mask   = writedata[W-1:0];
                3'd4: m_ren    = writedata[W-1:0];
                3'd5: m_fen    = writedata[W-1:0];
                3'd6: m_period = writedata[15:0];
                default: ;
            endcase
        end
        hist.push_back(in_port);
        void'(hist.pop_front());
    endtask

    task automatic step(input logic [2:0] a, input logic cs, input logic wn,
                        input logic [31:0] wd, input logic [W-1:0] pins);
        address = a; chipselect = cs; write_n = wn; writedata = wd; in_port = pins;
        @(posedge clk);
        model_edge();
        #1;
        check_eq("readdata", readdata, m_rd);
        check_eq("irq", 32'(irq), 32'(m_irq));
    endtask

    task automatic wr_reg(input logic [2:0] a, input logic [31:0] wd, input logic [W-1:0] pins);
        step(a, 1'b1, 1'b0, wd, pins);
    endtask

    task automatic idle(input logic [2:0] a, input int n, input logic [W-1:0] pins);
        for (int k = 0; k < n; k++) step(a, 1'b0, 1'b1, 32'h0, pins);
    endtask

    initial begin
        int first;
        logic [W-1:0] pins;
        logic [2:0]   ra;
        logic [31:0]  wd;

        reset_n = 1'b0; address = '0; chipselect = 1'b0; write_n = 1'b1;
        writedata = '0; in_port = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_readdata", readdata, 32'h0);
        check_eq("reset_irq", 32'(irq), 32'h0);
        reset_n = 1'b1;

        for (int a = 0; a < 8; a++) idle(3'(a), 1, '0);
        idle(3'd6, 1, '0);
        check_eq("reset_db_period", readdata, 32'd1000);

        // Debounce: a 5-cycle pulse is rejected, a 6-cycle hold is accepted.
        wr_reg(3'd6, 32'd5, '0);
        idle(3'd0, 3, 4'h0);
        idle(3'd0, 5, 4'h1);
        idle(3'd0, 12, 4'h0);
        check_eq("short_pulse_data", readdata, 32'h0);
        idle(3'd3, 1, 4'h0);
        check_eq("short_pulse_ec", readdata, 32'h0);
        first = 0;
        for (int k = 1; k <= 40; k++) begin
            step(3'd0, 1'b0, 1'b1, 32'h0, 4'h1);
            if (readdata[0] && first == 0) first = k;
        end
        // Debounced after S+6 edges, visible on the registered read one edge later.
        check_eq("db_latency", 32'(first), 32'(S + 7));

        // Rising-edge interrupt.
        wr_reg(3'd6, 32'd0, 4'h1);
        idle(3'd0, 6, 4'h0);
        wr_reg(3'd4, 32'h1, 4'h0);
        wr_reg(3'd2, 32'h1, 4'h0);
        idle(3'd3, 2, 4'h1);
        idle(3'd3, 6, 4'h0);
        check_eq("rise_ec", readdata, 32'h1);
        check_eq("rise_irq", 32'(irq), 32'h1);
        wr_reg(3'd3, 32'h1, 4'h0);
        check_eq("irq_after_clr_write", 32'(irq), 32'h1);
        idle(3'd3, 1, 4'h0);
        check_eq("ec_cleared", readdata, 32'h0);
        check_eq("irq_dropped", 32'(irq), 32'h0);

        // Fall-only capture on bit 1.
        wr_reg(3'd4, 32'h0, 4'h0);
        wr_reg(3'd5, 32'h2, 4'h0);
        wr_reg(3'd2, 32'h0, 4'h0);
        wr_reg(3'd3, 32'hF, 4'h0);
        idle(3'd3, 6, 4'h2);
        check_eq("fall_no_rise", readdata, 32'h0);
        idle(3'd3, 6, 4'h0);
        check_eq("fall_captured", readdata, 32'h2);

        // Falling edge on bit 1 coincides with a clear of bit 1: set wins.
        wr_reg(3'd3, 32'hF, 4'h0);
        idle(3'd3, 6, 4'h2);
        idle(3'd3, 3, 4'h0);
        wr_reg(3'd3, 32'h2, 4'h0);
        idle(3'd3, 1, 4'h0);
        check_eq("set_beats_clear", readdata, 32'h2);

        // Level mode on bit 3.
        wr_reg(3'd5, 32'h0, 4'h0);
        wr_reg(3'd2, 32'h8, 4'h0);
        idle(3'd0, 5, 4'h8);
        check_eq("level_data3", 32'(readdata[3]), 32'h1);
        check_eq("level_irq", 32'(irq), 32'h1);
        idle(3'd0, 5, 4'h0);
        check_eq("level_irq_low", 32'(irq), 32'h0);

        // Randomised traffic against the model.
        pins = '0;
        for (int n = 0; n < 3000; n++) begin
            for (int b = 0; b < W; b++)
                if ($urandom_range(0, 7) == 0) pins[b] = ~pins[b];
            ra = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 4) == 0) begin
                wd = $urandom;
                if (ra == 3'd6) wd = (wd & 32'hFFFF_0000) | 32'($urandom_range(0, 4));
                wr_reg(ra, wd, pins);
            end else begin
                step(ra, $urandom_range(0, 1) == 1, 1'b1, $urandom, pins);
            end
        end

        // Reset in the middle of a pending debounce.
        wr_reg(3'd4, 32'h0, 4'hF);
        wr_reg(3'd5, 32'h0, 4'hF);
        wr_reg(3'd2, 32'hF, 4'hF);
        wr_reg(3'd6, 32'h0, 4'hF);
        idle(3'd0, 6, 4'hF);
        check_eq("pre_reset_irq", 32'(irq), 32'h1);
        wr_reg(3'd6, 32'd10, 4'hF);
        idle(3'd0, 5, 4'h0);
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("async_reset_readdata", readdata, 32'h0);
        check_eq("async_reset_irq", 32'(irq), 32'h0);
        model_reset();
        #2;
        reset_n = 1'b1;
        idle(3'd0, 10, 4'h0);
        idle(3'd6, 1, 4'h0);
        check_eq("post_reset_period", readdata, 32'd1000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
